// File: rtl/ram_reader.sv
// ram_reader: burst reader for a small combinational-read RAM.
// On START it fetches LEN words (clamped to 16) beginning at BASE, with
// address wrap at 15. Each word is offered on DOUT/DVALID and held until
// the consumer accepts it with DREADY. While a burst is running, the block
// counts the accepted words that have bit 0 set and the ones that have bit 3 set.
module ram_reader (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [3:0] BASE,
  input  logic [4:0] LEN,
  output logic [3:0] A,
  output logic       WE,
  input  logic [3:0] Do,
  output logic [3:0] DOUT,
  output logic       DVALID,
  input  logic       DREADY,
  output logic       BUSY,
  output logic       DONE,
  output logic [4:0] F1_CNT,
  output logic [4:0] COUT_CNT
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  localparam logic [4:0] MAX_LEN  = 5'd16;

  // Lengths above 16 collapse to a full sweep of the 16-word RAM.
  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    if (len > MAX_LEN) begin
      return MAX_LEN;
    end else begin
      return len;
    end
  endfunction

  // Beat counter increment. The value stops at 16, which a clamped burst can never exceed.
  function automatic logic [4:0] sat_inc(input logic [4:0] cnt, input logic en);
    if (en && (cnt != MAX_LEN)) begin
      return cnt + 5'd1;
    end else begin
      return cnt;
    end
  endfunction

  logic [1:0] state_r,  state_s;
  logic [3:0] addr_r,   addr_s;
  logic [3:0] dout_r,   dout_s;
  logic       dvalid_r, dvalid_s;
  logic [4:0] rem_r,    rem_s;
  logic [4:0] f1_r,     f1_s;
  logic [4:0] cout_r,   cout_s;
  logic       busy_r,   busy_s;
  logic       done_r,   done_s;
  logic [4:0] eff_len_s;
  logic       beat_s;

  assign eff_len_s = clamp_len(LEN);
  assign beat_s    = (state_r == ST_SEND) && dvalid_r && DREADY;

  // Next-state and next-datapath computation for the burst sequencer.
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    dout_s   = dout_r;
    dvalid_s = dvalid_r;
    rem_s    = rem_r;
    f1_s     = f1_r;
    cout_s   = cout_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          f1_s   = 5'd0;
          cout_s = 5'd0;
          if (eff_len_s != 5'd0) begin
            addr_s  = BASE;
            rem_s   = eff_len_s;
            state_s = ST_FETCH;
          end else begin
            rem_s   = 5'd0;
            state_s = ST_FIN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        dout_s   = Do;
        dvalid_s = 1'b1;
        state_s  = ST_SEND;
      end
      ST_SEND: begin
        if (beat_s) begin
          dvalid_s = 1'b0;
          rem_s    = rem_r - 5'd1;
          f1_s     = sat_inc(f1_r, dout_r[0]);
          cout_s   = sat_inc(cout_r, dout_r[3]);
          if (rem_r > 5'd1) begin
            addr_s  = addr_r + 4'd1;
            state_s = ST_FETCH;
          end else begin
            state_s = ST_FIN;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        dvalid_s = 1'b0;
        state_s  = ST_IDLE;
      end
    endcase
  end

  // Status flags are derived from the next state so that they leave the block registered.
  always_comb begin
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_FIN);
  end

  // State and output registers. Reset clears them immediately, so a burst interrupted by reset is abandoned.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= ST_IDLE;
      addr_r   <= 4'd0;
      dout_r   <= 4'd0;
      dvalid_r <= 1'b0;
      rem_r    <= 5'd0;
      f1_r     <= 5'd0;
      cout_r   <= 5'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      addr_r   <= addr_s;
      dout_r   <= dout_s;
      dvalid_r <= dvalid_s;
      rem_r    <= rem_s;
      f1_r     <= f1_s;
      cout_r   <= cout_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign A        = addr_r;
  assign WE       = 1'b0;
  assign DOUT     = dout_r;
  assign DVALID   = dvalid_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;
  assign F1_CNT   = f1_r;
  assign COUT_CNT = cout_r;

endmodule

// File: doc/ram_reader.md
RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 START  input  1  single-cycle burst request; sampled only in IDLE.
REQ-005 BASE  input  4  first word address, sampled with START.
REQ-006 LEN  input  5  burst length in words, 0..16, sampled with START; values 17..31 SHALL be treated as 16.
REQ-007 A  output  4  RAM address, registered.
REQ-008 WE  output  1  RAM write enable, constant 0.
REQ-009 Do  input  4  RAM read data, combinational from A.
REQ-010 DOUT  output  4  captured word, registered.
REQ-011 DVALID  output  1  DOUT holds an unaccepted word.
REQ-012 DREADY  input  1  consumer accepts DOUT when DVALID=1 and DREADY=1 at a rising edge (beat).
REQ-013 BUSY  output  1  high in every state except IDLE.
REQ-014 DONE  output  1  one-cycle pulse at burst end.
REQ-015 F1_CNT  output  5  number of accepted beats in the current burst with DOUT[0]=1.
REQ-016 COUT_CNT  output  5  number of accepted beats in the current burst with DOUT[3]=1.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, SEND and FIN.
REQ-018 IDLE with START=1 and effective LEN>0 SHALL load A=BASE and remaining=LEN, clear F1_CNT and COUT_CNT, and go to FETCH.
REQ-019 IDLE with START=1 and LEN=0 SHALL clear both counters and go to FIN; no beats occur.
REQ-020 FETCH SHALL register DOUT<=Do, set DVALID=1 and go to SEND; this takes exactly one cycle.
REQ-021 In SEND, DOUT and DVALID SHALL be held stable until a beat occurs.
REQ-022 On a beat, DVALID SHALL clear and remaining SHALL decrement.
REQ-023 On a beat, F1_CNT SHALL increment if DOUT[0]=1.
REQ-024 On a beat, COUT_CNT SHALL increment if DOUT[3]=1.
REQ-025 On a beat with remaining>1, A SHALL advance to A+1 modulo 16 (15 wraps to 0) and the FSM SHALL go to FETCH.
REQ-026 On a beat with remaining=1, the FSM SHALL go to FIN.
REQ-027 FIN SHALL assert DONE for exactly one cycle and return to IDLE.
REQ-028 Counter values SHALL hold in IDLE until the next accepted START.
REQ-029 Latency: with START sampled at edge n, BUSY=1 and A=BASE SHALL be valid after edge n, and DVALID=1 after edge n+1.
REQ-030 Peak throughput SHALL be one word per two cycles.
REQ-031 START while BUSY=1 SHALL be ignored.
REQ-032 A beat in the same cycle as a new START SHALL not occur, because START is sampled only in IDLE.
REQ-033 A 16-word burst from any BASE SHALL visit each address exactly once, wrapping at 15.
REQ-034 Counters SHALL saturate at 16, which is the maximum reachable value.

Reset
REQ-035 RST_N=0 SHALL force immediately, without waiting for a clock edge: state=IDLE, A=0, DOUT=0, DVALID=0, BUSY=0, DONE=0, F1_CNT=0, COUT_CNT=0 and remaining=0; WE SHALL remain 0.
REQ-036 Reset asserted mid-burst SHALL abandon the burst with no DONE pulse, and no beat SHALL be counted on the reset edge.
REQ-037 After RST_N deasserts, the block SHALL accept START on the first rising edge.

Verification
REQ-038 RAM preloaded with word[i]=i, BASE=0, LEN=4, DREADY=1 -> DOUT sequence 0,1,2,3 on DVALID cycles 2 cycles apart; DONE one cycle after the 4th beat; F1_CNT=2, COUT_CNT=0.
REQ-039 Same RAM, BASE=14, LEN=4 -> A sequence 14,15,0,1; DOUT sequence 14,15,0,1; F1_CNT=2; COUT_CNT=2.
REQ-040 DREADY held 0 for 5 cycles in SEND with DOUT=9 -> DOUT=9 and DVALID=1 stable throughout; A unchanged; one beat counted when DREADY rises.
REQ-041 START with LEN=0 -> BUSY high for 1 cycle, DONE pulse, DVALID never 1, counters 0.
REQ-042 START pulsed again mid-burst -> ignored, burst completes with the original length; LEN=20 -> exactly 16 beats.
REQ-043 RST_N pulsed low during SEND of a burst of 8 -> all outputs 0 asynchronously, no DONE; a following START with BASE=3, LEN=1 yields a single word from address 3.
